// File: rtl/mem_responder_if.sv
// CPU-side load/store handshake bundle shared by the requester and mem_responder.
interface mem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: serves one load/store at a time against a word-wide
// synchronous RAM, doing read-modify-write for sub-word stores and returning
// zero-extended lane data for loads. Misaligned or illegal requests are answered
// with an error and never reach the RAM.
module mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_WORD = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_BYTE = 2'd2;
    // Final RD_WAIT cycle: the RAM has seen a stable address for MEM_LAT cycles.
    localparam logic [2:0] LAST_CNT  = 3'(MEM_LAT - 1);

    // Word accesses need addr[1:0]==0, halfwords addr[0]==0; size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_WORD: bad = (off != 2'd0);
            SIZE_HALF: bad = off[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Pull the addressed little-endian lane down to bit 0, upper bits zero.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] res;
        case (size)
            SIZE_WORD: res = word;
            SIZE_HALF: res = off[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            SIZE_BYTE: begin
                case (off)
                    2'd0:    res = {24'h000000, word[7:0]};
                    2'd1:    res = {24'h000000, word[15:8]};
                    2'd2:    res = {24'h000000, word[23:16]};
                    2'd3:    res = {24'h000000, word[31:24]};
                    default: res = 32'h0000_0000;
                endcase
            end
            default:   res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    // Replace only the addressed lane(s) of the old word with the store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                               input logic [15:0] data,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off);
        logic [31:0] res;
        case (size)
            SIZE_HALF: res = off[1] ? {data, word[15:0]} : {word[31:16], data};
            SIZE_BYTE: begin
                case (off)
                    2'd0:    res = {word[31:8], data[7:0]};
                    2'd1:    res = {word[31:16], data[7:0], word[7:0]};
                    2'd2:    res = {word[31:24], data[7:0], word[15:0]};
                    2'd3:    res = {data[7:0], word[23:0]};
                    default: res = word;
                endcase
            end
            default:   res = word;
        endcase
        return res;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [1:0]        off_r, off_nxt_s;
    logic [1:0]        size_r, size_nxt_s;
    logic              write_r, write_nxt_s;
    logic [15:0]       wdata_r, wdata_nxt_s;
    logic [2:0]        cnt_r, cnt_nxt_s;
    logic [ADDR_W-3:0] mem_addr_r, mem_addr_nxt_s;
    logic              mem_we_r, mem_we_nxt_s;
    logic [31:0]       mem_wdata_r, mem_wdata_nxt_s;
    logic              resp_valid_r, resp_valid_nxt_s;
    logic              resp_err_r, resp_err_nxt_s;
    logic [31:0]       resp_rdata_r, resp_rdata_nxt_s;
    logic              req_bad_s;
    logic              last_s;

    assign req_bad_s = is_misaligned(bus.req_size, bus.req_addr[1:0]);
    assign last_s    = (cnt_r == LAST_CNT);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_bad_s) begin
                        state_nxt_s = RESP;
                    end else if (!bus.req_write || (bus.req_size != SIZE_WORD)) begin
                        state_nxt_s = RD_WAIT;
                    end else begin
                        state_nxt_s = WR;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (last_s) begin
                    state_nxt_s = write_r ? WR : RESP;
                end else begin
                    state_nxt_s = RD_WAIT;
                end
            end
            WR:      state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Next values for the request latch, wait counter and registered outputs.
    always_comb begin
        off_nxt_s        = off_r;
        size_nxt_s       = size_r;
        write_nxt_s      = write_r;
        wdata_nxt_s      = wdata_r;
        cnt_nxt_s        = cnt_r;
        mem_addr_nxt_s   = mem_addr_r;
        mem_wdata_nxt_s  = mem_wdata_r;
        resp_rdata_nxt_s = resp_rdata_r;
        resp_err_nxt_s   = 1'b0;
        mem_we_nxt_s     = (state_nxt_s == WR);
        resp_valid_nxt_s = (state_nxt_s == RESP);
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    off_nxt_s      = bus.req_addr[1:0];
                    size_nxt_s     = bus.req_size;
                    write_nxt_s    = bus.req_write;
                    wdata_nxt_s    = bus.req_wdata[15:0];
                    cnt_nxt_s      = 3'd0;
                    resp_err_nxt_s = req_bad_s;
                    // An erroring request leaves the RAM interface untouched.
                    if (!req_bad_s) begin
                        mem_addr_nxt_s = bus.req_addr[ADDR_W-1:2];
                    end else begin
                        mem_addr_nxt_s = mem_addr_r;
                    end
                    if (state_nxt_s == WR) begin
                        mem_wdata_nxt_s = bus.req_wdata;
                    end else begin
                        mem_wdata_nxt_s = mem_wdata_r;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            RD_WAIT: begin
                cnt_nxt_s = cnt_r + 3'd1;
                if (last_s) begin
                    if (write_r) begin
                        mem_wdata_nxt_s = lane_merge(mem_rdata, wdata_r, size_r, off_r);
                    end else begin
                        resp_rdata_nxt_s = lane_extract(mem_rdata, size_r, off_r);
                    end
                end else begin
                    resp_rdata_nxt_s = resp_rdata_r;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // Request latch, wait counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            off_r        <= 2'd0;
            size_r       <= 2'd0;
            write_r      <= 1'b0;
            wdata_r      <= 16'h0000;
            cnt_r        <= 3'd0;
            mem_addr_r   <= '0;
            mem_we_r     <= 1'b0;
            mem_wdata_r  <= 32'h0000_0000;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'h0000_0000;
        end else begin
            off_r        <= off_nxt_s;
            size_r       <= size_nxt_s;
            write_r      <= write_nxt_s;
            wdata_r      <= wdata_nxt_s;
            cnt_r        <= cnt_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_we_r     <= mem_we_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
        end
    end

    // Reset kills a write or response already sitting in the output registers.
    assign bus.req_ready  = (state_r == IDLE) & ~reset;
    assign bus.resp_valid = resp_valid_r & ~reset;
    assign bus.resp_err   = resp_err_r & ~reset;
    assign bus.resp_rdata = resp_rdata_r;
    assign mem_addr       = mem_addr_r;
    assign mem_we         = mem_we_r & ~reset;
    assign mem_wdata      = mem_wdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with MEM_LAT=1 for most cases and
// one with MEM_LAT=3 for latency-dependent paths, each backed by a small RAM model.
module tb_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    // Clock generation.
    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_W(32)) bus1 ();
    mem_responder_if #(.ADDR_W(32)) bus3 ();

    logic [29:0] mem_addr1, mem_addr3;
    logic        mem_we1, mem_we3;
    logic [31:0] mem_wdata1, mem_wdata3;
    logic [31:0] rdata1, rdata3;

    mem_responder #(.ADDR_W(32), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(rdata1)
    );

    mem_responder #(.ADDR_W(32), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .bus(bus3),
        .mem_addr(mem_addr3), .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(rdata3)
    );

    logic [31:0] ram1 [16];
    logic [31:0] ram3 [16];
    logic [31:0] pipe0, pipe1;
    logic        bd_we   = 1'b0;
    logic [3:0]  bd_idx  = 4'd0;
    logic [31:0] bd_data = 32'h0;
    int we_cnt1 = 0, we_cnt3 = 0, resp_cnt1 = 0;
    int checks_cnt = 0, errors_cnt = 0;

    // RAM models: backdoor preload or DUT writes; u3 reads through two extra stages.
    always @(posedge clk) begin
        if (bd_we) begin
            ram1[bd_idx] <= bd_data;
            ram3[bd_idx] <= bd_data;
        end else begin
            if (mem_we1) ram1[mem_addr1[3:0]] <= mem_wdata1;
            if (mem_we3) ram3[mem_addr3[3:0]] <= mem_wdata3;
        end
        if (mem_we1) we_cnt1 <= we_cnt1 + 1;
        if (mem_we3) we_cnt3 <= we_cnt3 + 1;
        if (bus1.resp_valid) resp_cnt1 <= resp_cnt1 + 1;
        pipe0 <= ram3[mem_addr3[3:0]];
        pipe1 <= pipe0;
    end

    assign rdata1 = ram1[mem_addr1[3:0]];
    assign rdata3 = pipe1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [3:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = idx; bd_data = data;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Present one request for a single cycle; returns at the negedge after acceptance.
    task automatic send1(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus1.req_write = w; bus1.req_size = sz; bus1.req_addr = a; bus1.req_wdata = d;
        bus1.req_valid = 1'b1;
        check_val("u1_ready_before_req", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        bus1.req_valid = 1'b0;
    endtask

    task automatic send3(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus3.req_write = w; bus3.req_size = sz; bus3.req_addr = a; bus3.req_wdata = d;
        bus3.req_valid = 1'b1;
        check_val("u3_ready_before_req", 32'(bus3.req_ready), 32'd1);
        @(negedge clk);
        bus3.req_valid = 1'b0;
    endtask

    // Latency counts cycles after acceptance; -1 means no response within the budget.
    task automatic wait1(output int lat, output logic err, output logic [31:0] rd);
        lat = 1;
        while (!bus1.resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus1.resp_valid) lat = -1;
        err = bus1.resp_err;
        rd  = bus1.resp_rdata;
    endtask

    task automatic wait3(output int lat, output logic err, output logic [31:0] rd);
        lat = 1;
        while (!bus3.resp_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus3.resp_valid) lat = -1;
        err = bus3.resp_err;
        rd  = bus3.resp_rdata;
    endtask

    // Directed sequence.
    initial begin
        int lat;
        logic err;
        logic [31:0] rd;
        int we0, rs0;

        bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_size = 2'd0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_size = 2'd0;
        bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_ready", 32'(bus1.req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
        check_val("rst_resp_err", 32'(bus1.resp_err), 32'd0);
        check_val("rst_resp_rdata", bus1.resp_rdata, 32'h0);
        check_val("rst_mem_addr", 32'(mem_addr1), 32'h0);
        check_val("rst_mem_we", 32'(mem_we1), 32'd0);
        check_val("rst_mem_wdata", mem_wdata1, 32'h0);
        check_val("rst_ready_u3", 32'(bus3.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_val("ready_after_rst", 32'(bus1.req_ready), 32'd1);

        poke(4'd4, 32'hDEAD_BEEF);
        poke(4'd1, 32'h1122_3344);

        // Word load
        send1(1'b0, 2'd0, 32'h10, 32'h0);
        wait1(lat, err, rd);
        check_val("wload_lat", 32'(lat), 32'd2);
        check_val("wload_err", 32'(err), 32'd0);
        check_val("wload_data", rd, 32'hDEAD_BEEF);
        check_val("wload_mem_addr", 32'(mem_addr1), 32'd4);

        // Sub-word loads
        send1(1'b0, 2'd2, 32'h07, 32'h0);
        wait1(lat, err, rd);
        check_val("bload_lat", 32'(lat), 32'd2);
        check_val("bload_data", rd, 32'h0000_0011);
        send1(1'b0, 2'd1, 32'h04, 32'h0);
        wait1(lat, err, rd);
        check_val("hload_data", rd, 32'h0000_3344);

        // Byte store: read-modify-write
        we0 = we_cnt1;
        send1(1'b1, 2'd2, 32'h06, 32'h5555_55AB);
        wait1(lat, err, rd);
        check_val("bstore_lat", 32'(lat), 32'd3);
        check_val("bstore_err", 32'(err), 32'd0);
        check_val("bstore_rdata_held", rd, 32'h0000_3344);
        check_val("bstore_we_pulses", 32'(we_cnt1 - we0), 32'd1);
        check_val("bstore_wdata", mem_wdata1, 32'h11AB_3344);
        check_val("bstore_ram", ram1[1], 32'h11AB_3344);

        // Half store
        poke(4'd1, 32'h1122_3344);
        send1(1'b1, 2'd1, 32'h06, 32'h1234_BEEF);
        wait1(lat, err, rd);
        check_val("hstore_ram", ram1[1], 32'hBEEF_3344);

        // Word store
        we0 = we_cnt1;
        send1(1'b1, 2'd0, 32'h20, 32'h0102_0304);
        wait1(lat, err, rd);
        check_val("wstore_lat", 32'(lat), 32'd2);
        check_val("wstore_ram", ram1[8], 32'h0102_0304);
        check_val("wstore_we_pulses", 32'(we_cnt1 - we0), 32'd1);

        // Error responses
        we0 = we_cnt1;
        send1(1'b0, 2'd0, 32'h02, 32'h0);
        wait1(lat, err, rd);
        check_val("mis_wload_lat", 32'(lat), 32'd1);
        check_val("mis_wload_err", 32'(err), 32'd1);
        check_val("mis_wload_rdata", rd, 32'h0000_3344);
        send1(1'b1, 2'd1, 32'h05, 32'h0000_CAFE);
        wait1(lat, err, rd);
        check_val("mis_hstore_lat", 32'(lat), 32'd1);
        check_val("mis_hstore_err", 32'(err), 32'd1);
        send1(1'b0, 2'd3, 32'h00, 32'h0);
        wait1(lat, err, rd);
        check_val("size3_err", 32'(err), 32'd1);
        check_val("size3_rdata", rd, 32'h0000_3344);
        repeat (2) @(negedge clk);
        check_val("err_no_we", 32'(we_cnt1 - we0), 32'd0);
        check_val("err_ram_kept", ram1[1], 32'hBEEF_3344);

        // Reset while waiting on the read of a byte store
        poke(4'd1, 32'h1122_3344);
        we0 = we_cnt1; rs0 = resp_cnt1;
        send1(1'b1, 2'd2, 32'h04, 32'h0000_0077);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_rdwait_ready", 32'(bus1.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check_val("rst_rdwait_we", 32'(we_cnt1 - we0), 32'd0);
        check_val("rst_rdwait_resp", 32'(resp_cnt1 - rs0), 32'd0);
        check_val("rst_rdwait_ram", ram1[1], 32'h1122_3344);

        // Reset during the write cycle itself
        send1(1'b1, 2'd2, 32'h04, 32'h0000_0077);
        @(negedge clk);
        check_val("wr_we_high", 32'(mem_we1), 32'd1);
        reset = 1'b1;
        #1;
        check_val("rst_wr_we_gated", 32'(mem_we1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("rst_wr_ready", 32'(bus1.req_ready), 32'd1);
        repeat (4) @(negedge clk);
        check_val("rst_wr_we", 32'(we_cnt1 - we0), 32'd0);
        check_val("rst_wr_resp", 32'(resp_cnt1 - rs0), 32'd0);
        check_val("rst_wr_ram", ram1[1], 32'h1122_3344);

        // Busy: request held with new fields while a load is in flight
        @(negedge clk);
        bus1.req_write = 1'b0; bus1.req_size = 2'd0; bus1.req_addr = 32'h10;
        bus1.req_wdata = 32'h0; bus1.req_valid = 1'b1;
        @(negedge clk);
        bus1.req_write = 1'b1; bus1.req_addr = 32'h04; bus1.req_wdata = 32'h9999_9999;
        #1;
        check_val("busy_not_ready", 32'(bus1.req_ready), 32'd0);
        wait1(lat, err, rd);
        check_val("busy_load_lat", 32'(lat), 32'd2);
        check_val("busy_load_data", rd, 32'hDEAD_BEEF);
        check_val("busy_ram_untouched", ram1[1], 32'h1122_3344);
        @(negedge clk);
        check_val("busy_ready_again", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        wait1(lat, err, rd);
        check_val("busy_store_lat", 32'(lat), 32'd2);
        check_val("busy_store_ram", ram1[1], 32'h9999_9999);

        // MEM_LAT = 3 instance
        poke(4'd1, 32'h1122_3344);
        send3(1'b0, 2'd0, 32'h10, 32'h0);
        wait3(lat, err, rd);
        check_val("l3_wload_lat", 32'(lat), 32'd4);
        check_val("l3_wload_data", rd, 32'hDEAD_BEEF);
        send3(1'b0, 2'd1, 32'h04, 32'h0);
        wait3(lat, err, rd);
        check_val("l3_hload_data", rd, 32'h0000_3344);
        we0 = we_cnt3;
        send3(1'b1, 2'd2, 32'h06, 32'h0000_00AB);
        wait3(lat, err, rd);
        check_val("l3_bstore_lat", 32'(lat), 32'd5);
        check_val("l3_bstore_ram", ram3[1], 32'h11AB_3344);
        check_val("l3_bstore_we", 32'(we_cnt3 - we0), 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
